seq101_tx: RTL and testbench



---
 rtl/seq101_pkg.sv | 21 ++
 rtl/seq101_tx_if.sv | 11 +
 rtl/seq101_shifter.sv | 30 +++
 rtl/seq101_tx.sv | 129 ++++++++++++
 tb/tb_seq101_tx.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/seq101_pkg.sv
// Shared types and constants for the 101-sync serial frame transmitter.
package seq101_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } tx_state_t;

    localparam int                  SYNC_LEN     = 3;
    localparam logic [SYNC_LEN-1:0] SYNC_PATTERN = 3'b101;

    // Largest of three lengths; sizes the shared bit counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq101_tx_if.sv
// Load handshake between a word producer and the transmitter.
interface seq101_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_in;
    logic              load;
    logic              ready;

    modport master (output data_in, output load, input ready);
    modport slave  (input data_in, input load, output ready);
endinterface

// File: rtl/seq101_shifter.sv
// Parallel-load, left-shift payload register with zero fill.
module seq101_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              msb_o,
    output logic              next_msb_o
);
    logic [DATA_W-1:0] sreg_q;

    // Load wins over shift; the FSM never asserts both in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sreg_q <= '0;
        end else if (load_i) begin
            sreg_q <= data_i;
        end else if (shift_i) begin
            sreg_q <= {sreg_q[DATA_W-2:0], 1'b0};
        end
    end

    // next_msb_o is the MSB after the pending shift, used to pre-register x_out.
    assign msb_o      = sreg_q[DATA_W-1];
    assign next_msb_o = sreg_q[DATA_W-2];

endmodule

// File: rtl/seq101_tx.sv
// Frame transmitter: sync 1,0,1 then payload MSB first then idle zeros.
//
// state | meaning
// IDLE  | line held at 0, ready for a load
// SYNC  | sending the 3-bit 1,0,1 header
// DATA  | sending payload bits MSB first
// GAP   | idle zeros; last cycle pulses frame_done and may accept a load
module seq101_tx
    import seq101_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int GAP_BITS = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    seq101_tx_if.slave  tx,
    output logic        x_out,
    output logic        busy,
    output logic        frame_done
);
    localparam int CNT_W = $clog2(max3(SYNC_LEN, DATA_W, GAP_BITS));
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);

    tx_state_t           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                x_q, x_d;
    logic                done_q, done_d;
    logic                sh_load, sh_shift, sh_msb, sh_next;
    logic [SYNC_LEN-1:0] sync_sh;

    seq101_shifter #(.DATA_W(DATA_W)) u_shifter (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (sh_load),
        .shift_i    (sh_shift),
        .data_i     (tx.data_in),
        .msb_o      (sh_msb),
        .next_msb_o (sh_next)
    );

    assign tx.ready   = (state_q == IDLE) || ((state_q == GAP) && (cnt_q == GAP_LAST));
    assign busy       = (state_q != IDLE);
    assign x_out      = x_q;
    assign frame_done = done_q;

    // State, counter and registered line outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            done_q  <= done_d;
        end
    end

    // Next state and counter; outputs are derived from the next state so
    // x_out/frame_done line up with the cycle they describe.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        x_d      = 1'b0;
        done_d   = 1'b0;
        sync_sh  = '0;

        case (state_q)
            IDLE: begin
                if (tx.load) begin
                    state_d = SYNC;
                    cnt_d   = '0;
                    sh_load = 1'b1;
                end
            end
            SYNC: begin
                if (cnt_q == SYNC_LAST) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                sh_shift = 1'b1;
                if (cnt_q == DATA_LAST) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (tx.load) begin
                        state_d = SYNC;
                        sh_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Entering DATA from SYNC the register has not shifted yet; within
        // DATA the bit after this cycle's shift is the next one on the line.
        sync_sh = SYNC_PATTERN << cnt_d;
        case (state_d)
            SYNC:    x_d = sync_sh[SYNC_LEN-1];
            DATA:    x_d = (state_q == DATA) ? sh_next : sh_msb;
            default: x_d = 1'b0;
        endcase
        done_d = (state_d == GAP) && (cnt_d == GAP_LAST);
    end

endmodule

// File: tb/tb_seq101_tx.sv
module tb_seq101_tx;

    localparam int W0 = 8;
    localparam int L0 = 3 + W0 + 2;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    seq101_tx_if #(.DATA_W(8))  bus0 ();
    seq101_tx_if #(.DATA_W(2))  bus1 ();
    seq101_tx_if #(.DATA_W(16)) bus2 ();
    logic x0, busy0, fd0, x1, busy1, fd1, x2, busy2, fd2;

    seq101_tx #(.DATA_W(8), .GAP_BITS(2)) dut0 (
        .clock(clock), .reset_n(reset_n), .tx(bus0.slave),
        .x_out(x0), .busy(busy0), .frame_done(fd0));
    seq101_tx #(.DATA_W(2), .GAP_BITS(2)) dut1 (
        .clock(clock), .reset_n(reset_n), .tx(bus1.slave),
        .x_out(x1), .busy(busy1), .frame_done(fd1));
    seq101_tx #(.DATA_W(16), .GAP_BITS(4)) dut2 (
        .clock(clock), .reset_n(reset_n), .tx(bus2.slave),
        .x_out(x2), .busy(busy2), .frame_done(fd2));

    int checks = 0;
    int failures = 0;

    // Reference model: position within the current frame (-1 = idle).
    int          m_pos = -1;
    logic [7:0]  m_word = '0;
    logic [2:0]  hist = '0;
    int          hits = 0;
    int          n;
    logic [63:0] xs;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_x();
        if (m_pos < 0)       return 1'b0;
        if (m_pos < 3)       return (m_pos != 1);
        if (m_pos < 3 + W0)  return m_word[W0 - 1 - (m_pos - 3)];
        return 1'b0;
    endfunction

    // One clock of DUT0 with the given inputs, checked against the model.
    task automatic cyc(input logic ld, input logic [7:0] d);
        logic rdy_m;
        bus0.load    = ld;
        bus0.data_in = d;
        rdy_m = (m_pos < 0) || (m_pos == L0 - 1);
        chk("ready", bus0.ready, rdy_m);
        @(posedge clock);
        if (rdy_m && ld) begin
            m_pos  = 0;
            m_word = d;
        end else if (m_pos >= 0) begin
            m_pos = (m_pos == L0 - 1) ? -1 : m_pos + 1;
        end
        #1;
        chk("x_out", x0, model_x());
        chk("frame_done", fd0, m_pos == L0 - 1);
        chk("busy", busy0, m_pos >= 0);
        hist = {hist[1:0], x0};
    endtask

    initial begin
        bus0.load = 1'b0; bus0.data_in = '0;
        bus1.load = 1'b0; bus1.data_in = '0;
        bus2.load = 1'b0; bus2.data_in = '0;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        chk("rst_x", x0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_ready", bus0.ready, 1'b1);
        chk("rst_done", fd0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;

        // Single frame A5, then idle
        cyc(1'b1, 8'hA5);
        for (int i = 0; i < 15; i++) cyc(1'b0, 8'h00);

        // Back-to-back: FF then held load with 00
        cyc(1'b1, 8'hFF);
        for (int i = 0; i < 25; i++) cyc(1'b1, 8'h00);
        for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00);

        // Load while busy is ignored
        cyc(1'b1, 8'h81);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00);
        cyc(1'b1, 8'h3C);
        for (int i = 0; i < 12; i++) cyc(1'b0, 8'h00);

        // Reset mid-frame at DATA bit 3 of F0
        cyc(1'b1, 8'hF0);
        while (m_pos != 6) cyc(1'b0, 8'h00);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_x", x0, 1'b0);
        chk("mid_rst_busy", busy0, 1'b0);
        chk("mid_rst_ready", bus0.ready, 1'b1);
        chk("mid_rst_done", fd0, 1'b0);
        m_pos = -1;
        @(negedge clock);
        reset_n = 1'b1;
        cyc(1'b1, 8'h0F);
        for (int i = 0; i < 14; i++) cyc(1'b0, 8'h00);

        // Loopback: one detector hit per 00 frame, on the third sync bit
        hits = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < L0; i++) begin
                cyc(i == 0, 8'h00);
                chk("det_z", hist == 3'b101, m_pos == 2);
                if (hist == 3'b101) hits++;
            end
        end
        chk_int("det_hits", hits, 3);

        // Randomized traffic
        for (int i = 0; i < 300; i++) cyc($urandom_range(0, 2) == 0, 8'($urandom));
        for (int i = 0; i < 14; i++) cyc(1'b0, 8'h00);

        // DATA_W=2, GAP_BITS=2, all ones: 7-cycle frame
        bus1.load = 1'b1; bus1.data_in = 2'b11;
        @(posedge clock); #1;
        bus1.load = 1'b0;
        n = 1; xs = {63'd0, x1};
        chk("w2_ready_low", bus1.ready, 1'b0);
        while (!fd1 && n < 40) begin
            @(posedge clock); #1;
            n++; xs = {xs[62:0], x1};
        end
        chk_int("w2_len", n, 7);
        chk_int("w2_stream", xs[6:0], {3'b101, 2'b11, 2'b00});
        @(posedge clock); #1;
        chk("w2_idle", busy1, 1'b0);

        // DATA_W=16, GAP_BITS=4, all ones: 23-cycle frame
        bus2.load = 1'b1; bus2.data_in = 16'hFFFF;
        @(posedge clock); #1;
        bus2.load = 1'b0;
        n = 1; xs = {63'd0, x2};
        while (!fd2 && n < 60) begin
            @(posedge clock); #1;
            n++; xs = {xs[62:0], x2};
        end
        chk_int("w16_len", n, 23);
        chk_int("w16_stream", xs[22:0], {3'b101, 16'hFFFF, 4'h0});
        @(posedge clock); #1;
        chk("w16_idle", busy2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
